// File: rtl/rtlola_sched_pkg.sv
// rtl/rtlola_sched_pkg.sv - shared types and constants for the RTLola evaluation scheduler
//
// Purpose : FSM state enum, pacing group count, period defaults, timestamp
//           width and the event record layout shared by the scheduler files.
// Ports   : none (package).
// Config  : RTLOLA_SCHED_TIMESTAMP_EN adds the enqueue-time field to ev_rec_t.
package rtlola_sched_pkg;

  localparam int NUM_PACE        = 2;
  localparam int TS_W            = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_PERIOD0_CYC = 100000;   // 1 ms at 100 MHz
  localparam int DEF_PERIOD1_CYC = 1000000;  // 10 ms at 100 MHz

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOT = 2'd1,
    HOLD = 2'd2
  } sched_state_e;

  // Event record at the default data width; the scheduler packs the same
  // layout (timestamp above data) at its own DATA_W.
  typedef struct packed {
`ifdef RTLOLA_SCHED_TIMESTAMP_EN
    logic [TS_W-1:0]              ts;
`endif
    logic signed [DEF_DATA_W-1:0] data;
  } ev_rec_t;

endpackage

// File: rtl/rtlola_event_fifo.sv
// rtl/rtlola_event_fifo.sv - small in-order event buffer with occupancy count
//
// Purpose : power-of-two deep FIFO; wrap-around pointers plus an occupancy
//           count. Push and pop in the same cycle are allowed when not full.
//           A word pushed into an empty FIFO becomes visible at o_rdata on the
//           following cycle.
// Ports   : i_clk, i_rst_n   clock, asynchronous active-low reset
//           i_push, i_wdata  write strobe / word (ignored when full)
//           i_pop            read strobe (ignored when empty)
//           o_rdata          head word
//           o_full, o_empty  registered occupancy flags
module rtlola_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy guards every read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/rtlola_eval_scheduler.sv
// rtl/rtlola_eval_scheduler.sv - event buffering, periodic pacing and slot issue for an RTLola monitor
//
// Purpose : buffers input events, derives two periodic pacing groups from
//           per-period cycle counters and issues one-cycle evaluation slots
//           to the monitor, spaced EVAL_CYC+2 cycles apart at minimum.
// Ports   : i_clk, i_rst_n      clock, asynchronous active-low reset
//           i_en                global enable (freezes counters, slot issue, hold)
//           i_ev_valid/o_ev_ready/i_ev_data   event input handshake
//           i_mon_ready         monitor can take a slot
//           o_mon_en            one-cycle slot strobe
//           o_mon_new_input     slot carries an event
//           o_mon_data          event value (held between slots)
//           o_mon_pace          pacing bits, valid with o_mon_en
//           o_deadline_miss     sticky per-group overrun flags
//           o_mon_ts            (RTLOLA_SCHED_TIMESTAMP_EN only) slot timestamp
// Config  : define RTLOLA_SCHED_TIMESTAMP_EN to add the cycle timestamp path.
module rtlola_eval_scheduler
  import rtlola_sched_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int PERIOD0_CYC = DEF_PERIOD0_CYC,
  parameter int PERIOD1_CYC = DEF_PERIOD1_CYC,
  parameter int CNT_W       = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int EVAL_CYC    = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_ev_valid,
  output logic                     o_ev_ready,
  input  logic signed [DATA_W-1:0] i_ev_data,
  input  logic                     i_mon_ready,
  output logic                     o_mon_en,
  output logic                     o_mon_new_input,
  output logic signed [DATA_W-1:0] o_mon_data,
  output logic [NUM_PACE-1:0]      o_mon_pace,
  output logic [NUM_PACE-1:0]      o_deadline_miss
`ifdef RTLOLA_SCHED_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]          o_mon_ts
`endif
);

  localparam int HOLD_W = (EVAL_CYC < 2) ? 1 : $clog2(EVAL_CYC + 1);
`ifdef RTLOLA_SCHED_TIMESTAMP_EN
  localparam int REC_W  = TS_W + DATA_W;
`else
  localparam int REC_W  = DATA_W;
`endif

  sched_state_e                     r_state;
  sched_state_e                     w_state_nxt;
  logic [HOLD_W-1:0]                r_hold;
  logic [HOLD_W-1:0]                w_hold_nxt;
  logic                             w_issue;
  logic                             r_live;

  logic [NUM_PACE-1:0][CNT_W-1:0]   r_cnt;
  logic [NUM_PACE-1:0][CNT_W-1:0]   w_last;
  logic [NUM_PACE-1:0]              w_expire;
  logic [NUM_PACE-1:0]              r_pend;
  logic [NUM_PACE-1:0]              w_pend_nxt;
  logic [NUM_PACE-1:0]              w_miss_set;
  logic [NUM_PACE-1:0]              r_miss;

  logic                             w_fifo_full;
  logic                             w_fifo_empty;
  logic                             w_push;
  logic                             w_pop;
  logic [REC_W-1:0]                 w_push_word;
  logic [REC_W-1:0]                 w_head_word;
  logic [DATA_W-1:0]                w_head_data;

  logic                             r_mon_en;
  logic                             r_mon_new;
  logic [DATA_W-1:0]                r_mon_data;
  logic [NUM_PACE-1:0]              r_mon_pace;

  // ---------------------------------------------------------------- FIFO
  // r_live keeps ev_ready low until the first edge after reset release.
  assign o_ev_ready = r_live & ~w_fifo_full;
  assign w_push     = i_ev_valid & o_ev_ready;
  assign w_pop      = w_issue & ~w_fifo_empty;

`ifdef RTLOLA_SCHED_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] r_mon_ts;
  logic [TS_W-1:0] w_head_ts;

  assign w_push_word = {r_ts, i_ev_data};
  assign w_head_ts   = w_head_word[REC_W-1:DATA_W];
  assign o_mon_ts    = r_mon_ts;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ts     <= '0;
      r_mon_ts <= '0;
    end else begin
      if (i_en)    r_ts     <= r_ts + 1'b1;
      if (w_issue) r_mon_ts <= w_fifo_empty ? r_ts : w_head_ts;
    end
  end
`else
  assign w_push_word = i_ev_data;
`endif
  assign w_head_data = w_head_word[DATA_W-1:0];

  rtlola_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata (w_push_word),
    .i_pop   (w_pop),
    .o_rdata (w_head_word),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // ------------------------------------------------------- pacing counters
  assign w_last[0] = CNT_W'(PERIOD0_CYC - 1);
  assign w_last[1] = CNT_W'(PERIOD1_CYC - 1);

  always_comb begin
    w_expire = '0;
    for (int i = 0; i < NUM_PACE; i++) begin
      w_expire[i] = i_en & (r_cnt[i] == w_last[i]);
    end
  end

  // A slot hands the current pend bits to the monitor; an expiry on that
  // same edge re-arms pend for the next slot and is never counted as a miss.
  assign w_pend_nxt = w_issue ? w_expire : (r_pend | w_expire);
  assign w_miss_set = w_expire & r_pend & {NUM_PACE{~w_issue}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_pend <= '0;
      r_miss <= '0;
    end else begin
      for (int i = 0; i < NUM_PACE; i++) begin
        if (w_expire[i])  r_cnt[i] <= '0;
        else if (i_en)    r_cnt[i] <= r_cnt[i] + 1'b1;
      end
      r_pend <= w_pend_nxt;
      r_miss <= r_miss | w_miss_set;
    end
  end

  assign o_deadline_miss = r_miss;

  // ------------------------------------------------------------ slot FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_en && i_mon_ready && ((r_pend != '0) || !w_fifo_empty)) begin
          w_issue     = 1'b1;
          w_state_nxt = SLOT;
        end
      end
      SLOT: begin
        // The strobe lasts exactly one cycle regardless of i_en.
        w_hold_nxt  = HOLD_W'(EVAL_CYC);
        w_state_nxt = (EVAL_CYC == 0) ? IDLE : HOLD;
      end
      HOLD: begin
        // Leaving on the 1->0 step gives a slot spacing of EVAL_CYC+2.
        if (i_en) begin
          if (r_hold <= HOLD_W'(1)) begin
            w_hold_nxt  = '0;
            w_state_nxt = IDLE;
          end else begin
            w_hold_nxt  = r_hold - 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // ------------------------------------------------------ slot outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mon_en   <= 1'b0;
      r_mon_new  <= 1'b0;
      r_mon_data <= '0;
      r_mon_pace <= '0;
    end else begin
      r_mon_en <= w_issue;
      if (w_issue) begin
        r_mon_pace <= r_pend;
        r_mon_new  <= ~w_fifo_empty;
        if (!w_fifo_empty) r_mon_data <= w_head_data;
      end
    end
  end

  assign o_mon_en        = r_mon_en;
  assign o_mon_new_input = r_mon_new;
  assign o_mon_data      = r_mon_data;
  assign o_mon_pace      = r_mon_pace;

endmodule

// File: tb/tb_rtlola_eval_scheduler.sv
// tb/tb_rtlola_eval_scheduler.sv - self-checking bench for rtlola_eval_scheduler
module tb_rtlola_eval_scheduler;

  localparam int P0 = 10;
  localparam int P1 = 25;
  localparam int EV = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        ev_valid = 1'b0;
  logic [31:0] ev_data = 32'd0;
  logic        mon_ready = 1'b0;
  logic        ev_ready;
  logic        mon_en;
  logic        mon_new;
  logic signed [31:0] mon_data;
  logic [1:0]  mon_pace;
  logic [1:0]  miss;
`ifdef RTLOLA_SCHED_TIMESTAMP_EN
  logic [31:0] mon_ts;
`endif

  always #5 clk = ~clk;

  rtlola_eval_scheduler #(
    .DATA_W      (32),
    .PERIOD0_CYC (P0),
    .PERIOD1_CYC (P1),
    .CNT_W       (24),
    .FIFO_DEPTH  (DEPTH),
    .EVAL_CYC    (EV)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_en            (en),
    .i_ev_valid      (ev_valid),
    .o_ev_ready      (ev_ready),
    .i_ev_data       (ev_data),
    .i_mon_ready     (mon_ready),
    .o_mon_en        (mon_en),
    .o_mon_new_input (mon_new),
    .o_mon_data      (mon_data),
    .o_mon_pace      (mon_pace),
    .o_deadline_miss (miss)
`ifdef RTLOLA_SCHED_TIMESTAMP_EN
    ,
    .o_mon_ts        (mon_ts)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: enabled-edge count drives period expiries by modulo,
  // the FIFO is a queue, and slot spacing is a count of blocked edges.
  int          m_edges;
  bit [1:0]    m_pend;
  bit [1:0]    m_miss;
  logic [31:0] q[$];
  int          m_gap;
  bit          m_slot;
  bit          m_live;
  bit          e_en;
  bit          e_new;
  bit          e_acc;
  bit [1:0]    e_pace;
  logic [31:0] e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_edges = 0; m_pend = 2'b00; m_miss = 2'b00; q.delete();
    m_gap = 0; m_slot = 1'b0; m_live = 1'b0;
    e_en = 1'b0; e_new = 1'b0; e_acc = 1'b0; e_pace = 2'b00; e_data = 32'd0;
  endtask

  task automatic model_step();
    bit ready;
    bit issue;
    bit [1:0] exp_b;
    ready = m_live && (q.size() < DEPTH);
    issue = (m_gap == 0) && en && mon_ready && ((m_pend != 2'b00) || (q.size() != 0));
    exp_b = 2'b00;
    if (en) begin
      m_edges++;
      if (m_edges % P0 == 0) exp_b[0] = 1'b1;
      if (m_edges % P1 == 0) exp_b[1] = 1'b1;
    end
    e_en  = issue;
    e_acc = ev_valid && ready;
    if (issue) begin
      e_pace = m_pend;
      e_new  = (q.size() != 0);
      if (e_new) e_data = q.pop_front();
      m_pend = exp_b;
      m_gap  = EV + 1;
      m_slot = 1'b1;
    end else begin
      m_miss = m_miss | (exp_b & m_pend);
      m_pend = m_pend | exp_b;
      if (m_slot) begin
        m_gap--;
        m_slot = 1'b0;
      end else if (m_gap > 0 && en) begin
        m_gap--;
      end
    end
    if (e_acc) q.push_back(ev_data);
    m_live = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    chk("mon_en", 32'(mon_en), 32'(e_en));
    chk("ev_ready", 32'(ev_ready), 32'(m_live && (q.size() < DEPTH)));
    chk("deadline_miss", 32'(miss), 32'(m_miss));
    chk("mon_data", mon_data, e_data);
    if (e_en) begin
      chk("mon_pace", 32'(mon_pace), 32'(e_pace));
      chk("mon_new_input", 32'(mon_new), 32'(e_new));
    end
  endtask

  initial begin
    int n_slots;
    int k;
    int cnt;
    bit found;
    logic [31:0] got[$];
    int slot_t[$];

    model_reset();
    // Reset state while rst_n is held low.
    @(negedge clk);
    chk("rst_ev_ready", 32'(ev_ready), 32'd0);
    chk("rst_mon_en", 32'(mon_en), 32'd0);
    chk("rst_mon_new", 32'(mon_new), 32'd0);
    chk("rst_mon_data", mon_data, 32'd0);
    chk("rst_mon_pace", 32'(mon_pace), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle periodic pacing and the group 0/1 collision at edge 50.
    en = 1'b1;
    mon_ready = 1'b1;
    n_slots = 0;
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (mon_en) n_slots++;
      if (t == 11 || t == 21 || t == 31 || t == 41)
        chk("idle_pace0", 32'({mon_en, mon_pace, mon_new}), 32'({1'b1, 2'b01, 1'b0}));
      if (t == 26) chk("idle_pace1", 32'({mon_en, mon_pace, mon_new}), 32'({1'b1, 2'b10, 1'b0}));
      if (t == 51) chk("collision", 32'({mon_en, mon_pace, mon_new}), 32'({1'b1, 2'b11, 1'b0}));
      if (t == 52) chk("collision_single", 32'(mon_en), 32'd0);
    end
    chk("idle_slot_count", 32'(n_slots), 32'd6);
    chk("idle_no_miss", 32'(miss), 32'd0);

    // Back-pressure: four events fill the FIFO, the fifth waits.
    mon_ready = 1'b0;
    k = 1;
    ev_valid = 1'b1;
    ev_data = 32'd1;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (e_acc) begin
        k++;
        ev_data = k;
      end
    end
    chk("bp_ready_low", 32'(ev_ready), 32'd0);
    tick();
    chk("bp_fifth_waits", 32'(ev_ready), 32'd0);
    mon_ready = 1'b1;
    for (int t = 0; t < 40 && got.size() < 5; t++) begin
      tick();
      if (e_acc) ev_valid = 1'b0;
      if (mon_en && mon_new) begin
        got.push_back(mon_data);
        slot_t.push_back(cyc);
      end
    end
    chk("bp_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < got.size(); i++) chk("bp_order", got[i], 32'(i + 1));
    for (int i = 0; i + 1 < slot_t.size(); i++)
      chk("bp_spacing", 32'(slot_t[i+1] - slot_t[i]), 32'd5);

    // Overrun: pacing group 0 expires twice with no slot.
    mon_ready = 1'b0;
    repeat (25) tick();
    chk("overrun_miss0", 32'(miss[0]), 32'd1);
    mon_ready = 1'b1;
    cnt = 0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      if (t == 1) chk("overrun_slot_now", 32'({mon_en, mon_pace[0]}), 32'd3);
      if (mon_en && mon_pace[0]) cnt++;
    end
    chk("overrun_one_slot", 32'(cnt), 32'd1);
    chk("overrun_sticky", 32'(miss[0]), 32'd1);

    // Asynchronous reset while the FSM is in HOLD.
    found = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (mon_en) begin
        found = 1'b1;
        break;
      end
    end
    chk("wait_slot", 32'(found), 32'd1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_mon_en", 32'(mon_en), 32'd0);
    chk("arst_miss", 32'(miss), 32'd0);
    chk("arst_mon_data", mon_data, 32'd0);
    chk("arst_ev_ready", 32'(ev_ready), 32'd0);
    @(negedge clk);
    chk("arst_hold_ready", 32'(ev_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle pacing after release, then a 7-cycle enable freeze with one event.
    for (int t = 1; t <= 40; t++) begin
      en = !(t >= 13 && t <= 19);
      ev_valid = (t == 14);
      ev_data = 32'hA5A5_0001;
      tick();
      if (t == 11) chk("post_rst_pace0", 32'({mon_en, mon_pace}), 32'({1'b1, 2'b01}));
      if (t == 10) chk("post_rst_early", 32'(mon_en), 32'd0);
      if (t == 23) chk("freeze_event_slot", 32'({mon_en, mon_new}), 32'b11);
      if (t == 27) chk("freeze_not_early", 32'(mon_en), 32'd0);
      if (t == 28) chk("freeze_pace0", 32'({mon_en, mon_pace[0]}), 32'b11);
    end
    ev_valid = 1'b0;

    // Randomised traffic against the reference model.
    for (int t = 0; t < 400; t++) begin
      en = ($urandom_range(0, 9) != 0);
      mon_ready = ($urandom_range(0, 3) != 0);
      ev_valid = ($urandom_range(0, 1) == 1);
      ev_data = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
